// File: rtl/mem_pkg.sv
// Shared types and default address map for the memory arbiter and its decode.
package mem_pkg;

   typedef logic [15:0] addr_t;
   typedef logic [7:0]  data_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   // Read-return tag launched with each granted access.
   typedef struct packed {
      owner_e owner;
      logic   read;
      logic   mapped;
   } rd_tag_t;

   localparam addr_t ROM_BASE_DEF      = 16'hF000;
   localparam addr_t RAM_SIZE_DEF      = 16'h0800;
   localparam addr_t RESET_VECTOR      = 16'hFFFC;
   localparam int    DMA_WAIT_MAX_DEF  = 4;
   localparam int    DMA_BURST_MAX_DEF = 8;

endpackage

// File: rtl/mem_decode.sv
// Address decode: RAM at the bottom of the map, ROM at the top, hole in between.
module mem_decode
   import mem_pkg::*;
#(
   parameter addr_t ROM_BASE = ROM_BASE_DEF,
   parameter addr_t RAM_SIZE = RAM_SIZE_DEF
) (
   input  addr_t addr,
   output logic  rom_sel,
   output logic  ram_sel,
   output logic  mapped
);

   // Region compare on the presented address.
   always_comb begin
      ram_sel = (addr < RAM_SIZE);
      rom_sel = (addr >= ROM_BASE);
      mapped  = ram_sel | rom_sel;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-cycle memory port between the 6502 core and the DMA/loader.
// The CPU wins by default; DMA is stalled at most DMA_WAIT_MAX cycles and may
// hold the bus for at most DMA_BURST_MAX consecutive cycles against a waiting CPU.
// Both limits are tracked by down-timers whose terminal count (zero) means
// "limit reached".
module mem_arbiter
   import mem_pkg::*;
#(
   parameter addr_t ROM_BASE      = ROM_BASE_DEF,
   parameter addr_t RAM_SIZE      = RAM_SIZE_DEF,
   parameter int    DMA_WAIT_MAX  = DMA_WAIT_MAX_DEF,
   parameter int    DMA_BURST_MAX = DMA_BURST_MAX_DEF
) (
   input  logic  ph2,
   input  logic  reset_b,
   input  logic  cpu_req,
   input  logic  cpu_we,
   input  addr_t cpu_addr,
   input  data_t cpu_wdata,
   output logic  cpu_rdy,
   output data_t cpu_rdata,
   output logic  cpu_rvalid,
   input  logic  dma_req,
   input  logic  dma_we,
   input  addr_t dma_addr,
   input  data_t dma_wdata,
   output logic  dma_gnt,
   output data_t dma_rdata,
   output logic  dma_rvalid,
   output logic  mem_en,
   output logic  mem_we,
   output addr_t mem_addr,
   output data_t mem_wdata,
   output logic  rom_sel,
   output logic  ram_sel,
   input  data_t mem_rdata,
   output logic  wr_err
);

   localparam int WAIT_W  = $clog2(DMA_WAIT_MAX + 1);
   localparam int BURST_W = $clog2(DMA_BURST_MAX + 1);

   logic [WAIT_W-1:0]  wait_tmr;
   logic [BURST_W-1:0] burst_tmr;
   logic               wait_tc;
   logic               burst_tc;
   logic               dma_win;
   logic               cpu_gnt;
   logic               active;
   logic               sel_we;
   addr_t              sel_addr;
   data_t              sel_wdata;
   logic               dec_rom;
   logic               dec_ram;
   logic               dec_mapped;
   rd_tag_t            tag;
   data_t              ret_data;
   data_t              cpu_rdata_q;
   data_t              dma_rdata_q;

   assign wait_tc  = (wait_tmr == '0);
   assign burst_tc = (burst_tmr == '0);

   // Grant decision and bus mux from registered timers.
   always_comb begin
      dma_win   = dma_req && (!cpu_req || wait_tc) && !(burst_tc && cpu_req);
      cpu_gnt   = cpu_req && !dma_win;
      active    = dma_win || cpu_gnt;
      sel_we    = dma_win ? dma_we    : cpu_we;
      sel_addr  = dma_win ? dma_addr  : cpu_addr;
      sel_wdata = dma_win ? dma_wdata : cpu_wdata;
   end

   mem_decode #(
      .ROM_BASE (ROM_BASE),
      .RAM_SIZE (RAM_SIZE)
   ) u_decode (
      .addr    (sel_addr),
      .rom_sel (dec_rom),
      .ram_sel (dec_ram),
      .mapped  (dec_mapped)
   );

   // Memory strobes; ROM and hole writes never reach the array.
   always_comb begin
      cpu_rdy   = !cpu_req || cpu_gnt;
      dma_gnt   = dma_win;
      mem_en    = active && (dec_ram || (dec_rom && !sel_we));
      mem_we    = active && sel_we && dec_ram;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      rom_sel   = active && dec_rom;
      ram_sel   = active && dec_ram;
   end

   // Wait and burst down-timers, reloaded whenever their run is broken.
   always_ff @(posedge ph2 or negedge reset_b) begin
      if (!reset_b) begin
         wait_tmr  <= WAIT_W'(DMA_WAIT_MAX);
         burst_tmr <= BURST_W'(DMA_BURST_MAX);
      end else begin
         if (!dma_req || dma_win)
            wait_tmr <= WAIT_W'(DMA_WAIT_MAX);
         else if (!wait_tc)
            wait_tmr <= wait_tmr - WAIT_W'(1);
         if (!dma_win)
            burst_tmr <= BURST_W'(DMA_BURST_MAX);
         else if (!burst_tc)
            burst_tmr <= burst_tmr - BURST_W'(1);
      end
   end

   // Launch the read-return tag and flag illegal writes for the next cycle.
   always_ff @(posedge ph2 or negedge reset_b) begin
      if (!reset_b) begin
         tag    <= '{owner: OWN_CPU, read: 1'b0, mapped: 1'b0};
         wr_err <= 1'b0;
      end else begin
         tag.owner  <= dma_win ? OWN_DMA : OWN_CPU;
         tag.read   <= active && !sel_we;
         tag.mapped <= dec_mapped;
         wr_err     <= active && sel_we && !dec_ram;
      end
   end

   // Route returning data to the tag owner; the other side keeps its last byte.
   always_comb begin
      ret_data   = tag.mapped ? mem_rdata : 8'h00;
      cpu_rvalid = tag.read && (tag.owner == OWN_CPU);
      dma_rvalid = tag.read && (tag.owner == OWN_DMA);
      cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
      dma_rdata  = dma_rvalid ? ret_data : dma_rdata_q;
   end

   // Hold registers for the per-requester read data.
   always_ff @(posedge ph2 or negedge reset_b) begin
      if (!reset_b) begin
         cpu_rdata_q <= 8'h00;
         dma_rdata_q <= 8'h00;
      end else begin
         cpu_rdata_q <= cpu_rdata;
         dma_rdata_q <= dma_rdata;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous memory port (ROM + RAM) between the 6502 core and a DMA/loader requester.
- Stalls the core through its RDY input while DMA owns the bus.
- Decodes the address into ROM/RAM selects and blocks writes to ROM.
- Sits inside top between the core, the DMA engine and mem.

Parameters:
- ROM_BASE, 16'hF000, first ROM address; addr >= ROM_BASE selects ROM (4 KB ROM at the top of the map).
- RAM_SIZE, 16'h0800, RAM occupies 0x0000..RAM_SIZE-1.
- DMA_WAIT_MAX, 4, consecutive denied DMA-request cycles before DMA is forced a grant.
- DMA_BURST_MAX, 8, consecutive DMA grants before a requesting CPU must get a cycle.

Ports:
- ph2  in  1  single system clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- cpu_req  in  1  core bus cycle request.
- cpu_we  in  1  core write.
- cpu_addr  in  16  core address.
- cpu_wdata  in  8  core write data.
- cpu_rdy  out  1  core may proceed this cycle (6502 RDY).
- cpu_rdata  out  8  read data to core.
- cpu_rvalid  out  1  cpu_rdata valid.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA write.
- dma_addr  in  16  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdata  out  8  read data to DMA.
- dma_rvalid  out  1  dma_rdata valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- rom_sel  out  1  access targets ROM.
- ram_sel  out  1  access targets RAM.
- mem_rdata  in  8  memory read data; valid the cycle after mem_en.
- wr_err  out  1  one-cycle pulse on an attempted ROM/unmapped write.

Behaviour:
- Bus protocol
  - Memory latency is 1: access issued in cycle N, data returned in N+1.
  - mem_* outputs are combinational from the granted requester.
  - Requesters hold req/addr/we/wdata stable until granted.
- Arbitration (combinational each cycle from registered state)
  - Default winner is the CPU.
  - DMA wins if dma_req and (!cpu_req, or wait_cnt==DMA_WAIT_MAX), unless burst_cnt==DMA_BURST_MAX and cpu_req, in which case the CPU wins.
  - Exactly one grant per cycle.
- Counters
  - wait_cnt: +1 per cycle with dma_req && !dma_gnt, saturating at DMA_WAIT_MAX; cleared on dma_gnt or !dma_req.
  - burst_cnt: +1 per dma_gnt, saturating at DMA_BURST_MAX; cleared on any cycle without dma_gnt.
- Outputs
  - cpu_rdy = !cpu_req || cpu granted.
  - dma_gnt = DMA granted.
- Address decode
  - ram_sel = addr < RAM_SIZE.
  - rom_sel = addr >= ROM_BASE.
  - mem_en = grant && (ram_sel || (rom_sel && !we)).
  - mem_we = grant && we && ram_sel.
- Illegal accesses
  - ROM or unmapped write: no memory write; wr_err pulses high the next cycle.
  - Unmapped read: returns 8'h00.
- Read return
  - Registered tag {owner, read, mapped} launched in cycle N.
  - In N+1 the owner's rvalid=1; rdata = mem_rdata if mapped, else 8'h00.
  - The other requester's rvalid=0; rdata holds its last value.
  - Writes produce no rvalid.
- Reset (reset_b low, asynchronous)
  - wait_cnt, burst_cnt and tag cleared.
  - cpu_rvalid, dma_rvalid, wr_err = 0; cpu_rdata, dma_rdata = 8'h00.
  - A read in flight when reset asserts is discarded; no rvalid after release.
  - Grants are combinational and may assert in the first cycle after release.

Decomposition:
- Shared package mem_pkg: addr_t (16b), data_t (8b), owner_e {OWN_CPU, OWN_DMA}, ROM_BASE/RAM_SIZE defaults, reset vector 16'hFFFC.
- Sub-module mem_decode: combinational address-to-{rom_sel, ram_sel, mapped} decode, reused by the arbiter and the bench checker.

Test Plan:
1. CPU-only: CPU writes 8'hFF to 16'h0071, then reads 16'h0071 -> cpu_rdy=1 throughout; cpu_rvalid=1 with cpu_rdata=8'hFF one cycle after the read grant.
2. Reset vector fetch: after reset_b release, CPU reads 16'hFFFC/16'hFFFD with ROM preloaded 00/F0 -> rom_sel=1; cpu_rdata 8'h00 then 8'hF0.
3. Contention: cpu_req and dma_req both held continuously -> DMA denied 4 cycles, granted on the 5th; cpu_rdy=0 exactly in that cycle.
4. DMA burst: dma_req held with cpu_req low for 8 cycles, then cpu_req raised and dma_req held -> dma_gnt for cycles 1-8; CPU wins cycle 9 once burst_cnt==8; DMA wins again by the wait rule.
5. ROM write: DMA writes 8'hAA to 16'hF000 -> mem_we=0, mem_en=0; wr_err pulse next cycle; subsequent read of 16'hF000 returns the original ROM byte.
6. Reset mid-read: CPU read granted, reset_b pulled low before the next edge -> cpu_rvalid stays 0; counters 0 after release.
